// File: rtl/ppcm_loader_pkg.sv
// ppcm_loader_pkg -- shared constants for the PPCM sample loader.
//   state_t        : loader FSM state encoding
//   WB_CTI_CLASSIC : Wishbone cycle type, classic single cycle
//   WB_BTE_LINEAR  : Wishbone burst type, linear
//   WB_SEL_WORD    : all four byte lanes selected
package ppcm_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [3:0] WB_SEL_WORD    = 4'b1111;

endpackage

// File: rtl/ppcm_loader_if.sv
// ppcm_loader_if -- Wishbone read master bus plus the downstream word stream.
//   master modport : loader side (drives wbm_*_o, out_data, out_valid)
//   slave modport  : bus slave / stream sink side
//   wbm_*          : Wishbone classic master signals
//   out_data/out_valid/out_ready : word stream, transfer on valid & ready
interface ppcm_loader_if #(
    parameter int ADDR_BITS = 32
);
    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [ADDR_BITS-1:0] wbm_addr_o;
    logic [2:0]           wbm_cti_o;
    logic [1:0]           wbm_bte_o;
    logic [3:0]           wbm_sel_o;
    logic [31:0]          wbm_data_o;
    logic [31:0]          wbm_data_i;
    logic                 wbm_ack_i;
    logic [31:0]          out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_cti_o,
               wbm_bte_o, wbm_sel_o, wbm_data_o, out_data, out_valid,
        input  wbm_data_i, wbm_ack_i, out_ready
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_cti_o,
               wbm_bte_o, wbm_sel_o, wbm_data_o, out_data, out_valid,
        output wbm_data_i, wbm_ack_i, out_ready
    );

endinterface

// File: rtl/ppcm_loader.sv
// ppcm_loader -- reads word_count 32-bit words over Wishbone starting at
// base_addr, one outstanding request at a time, and streams each word out.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : one-cycle launch pulse (ignored unless idle)
//   base_addr      : byte address of first word, bits [1:0] ignored
//   word_count     : number of words; zero finishes immediately
//   busy/done/error: status; done pulses once at the end, error with done on abort
//   bus            : Wishbone master + output stream (ppcm_loader_if.master)
// Optional build macro PPCM_LOADER_TIMEOUT_EN: abort a read after TIMEOUT
// cycles without ack; otherwise a read waits for ack indefinitely.
module ppcm_loader
    import ppcm_loader_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]  word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    ppcm_loader_if.master        bus
);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  remain_q;
    logic [31:0]          data_q;
    logic                 load, capture, advance, abort;
    logic                 tmo_expired;
    logic                 cyc, valid;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        abort   = 1'b0;
        cyc     = 1'b0;
        valid   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    state_d = (word_count == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                cyc = 1'b1;
                if (bus.wbm_ack_i) begin
                    capture = 1'b1;
                    state_d = ST_OUTPUT;
                end else if (tmo_expired) begin
                    abort   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_OUTPUT: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    advance = 1'b1;
                    state_d = (remain_q == LEN_BITS'(1)) ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- address / count / data ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
        end else begin
            if (load) begin
                addr_q   <= {base_addr[ADDR_BITS-1:2], 2'b00};
                remain_q <= word_count;
            end
            if (capture) data_q <= bus.wbm_data_i;
            // Address wraps naturally at 2^ADDR_BITS.
            if (advance) begin
                addr_q   <= addr_q + ADDR_BITS'(4);
                remain_q <= remain_q - LEN_BITS'(1);
            end
        end
    end

`ifdef PPCM_LOADER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // Held at zero outside READ, so every READ entry starts a fresh count;
    // the last allowed READ cycle is the one where the count is TIMEOUT-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      tmo_q <= '0;
        else if (state_q != ST_READ)  tmo_q <= '0;
        else if (state_d == ST_READ)  tmo_q <= tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err_q <= 1'b0;
        else if (load)  err_q <= 1'b0;
        else if (abort) err_q <= 1'b1;
    end

    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign error       = done & err_q;

    logic unused_ok;
    assign unused_ok = ^base_addr[1:0];
`else
    assign tmo_expired = 1'b0;
    assign error       = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{base_addr[1:0], abort, TIMEOUT};
`endif

    // ---------------- bus outputs ----------------
    assign bus.wbm_cyc_o  = cyc;
    assign bus.wbm_stb_o  = cyc;
    assign bus.wbm_we_o   = 1'b0;
    assign bus.wbm_addr_o = addr_q;
    assign bus.wbm_cti_o  = WB_CTI_CLASSIC;
    assign bus.wbm_bte_o  = WB_BTE_LINEAR;
    assign bus.wbm_sel_o  = WB_SEL_WORD;
    assign bus.wbm_data_o = 32'h0;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid;

endmodule

// File: tb/tb_ppcm_loader.sv
// tb_ppcm_loader -- randomized scoreboard bench for ppcm_loader.
// Stimulus pushes expected Wishbone addresses, stream words and done/error
// outcomes into queues; a monitor pops and compares as the DUT presents them.
module tb_ppcm_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy, done, error;

    ppcm_loader_if #(.ADDR_BITS(32)) bus();

    ppcm_loader #(.ADDR_BITS(32), .LEN_BITS(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int out_cnt = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_err_q[$];

    // slave / sink behaviour knobs
    int          fixed_delay = -1;
    bit          never_ack   = 1'b0;
    bit          spurious    = 1'b0;
    bit          rand_ready  = 1'b0;
    int          hold_cnt    = 0;
    logic [31:0] data_xor    = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Reference model: word i of a transfer lives at (base with low bits
    // cleared) + 4*i modulo 2^32 and returns that address xor the salt.
    task automatic expect_xfer(input logic [31:0] base, input int n, input logic [31:0] x);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(a ^ x);
        end
        exp_err_q.push_back(1'b0);
    endtask

    task automatic flush_model();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_err_q.delete();
    endtask

    // ---------------- Wishbone slave ----------------
    initial begin
        int  wcnt;
        bit  in_req;
        wcnt = 0;
        in_req = 1'b0;
        bus.wbm_ack_i  = 1'b0;
        bus.wbm_data_i = 32'h0;
        forever begin
            @(posedge clk); #2;
            bus.wbm_ack_i = 1'b0;
            if (rst) begin
                in_req = 1'b0;
                continue;
            end
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (!never_ack) begin
                    if (wcnt == 0) begin
                        bus.wbm_ack_i  = 1'b1;
                        bus.wbm_data_i = bus.wbm_addr_o ^ data_xor;
                        in_req = 1'b0;
                    end else begin
                        wcnt--;
                    end
                end
            end else begin
                in_req = 1'b0;
                // stray acks with junk data while no request is open
                if (spurious && $urandom_range(0, 3) == 0) begin
                    bus.wbm_ack_i  = 1'b1;
                    bus.wbm_data_i = $urandom;
                end
            end
        end
    end

    // ---------------- stream sink ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (hold_cnt > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0;
                hold_cnt--;
            end else begin
                bus.out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] held_data;
    bit          pend_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_valid = 1'b0;
                continue;
            end
            chk("cyc_eq_stb", bus.wbm_stb_o, bus.wbm_cyc_o);
            if (bus.wbm_cyc_o) chk("one_outstanding", bus.out_valid, 0);
            if (error) chk("error_with_done", done, 1);
            if (bus.wbm_cyc_o && bus.wbm_ack_i) begin
                if (exp_addr_q.size() == 0) fail_msg("unexpected_wb_request");
                else chk("wb_addr", bus.wbm_addr_o, exp_addr_q.pop_front());
            end
            if (bus.out_valid) begin
                if (pend_valid) chk("out_data_held", bus.out_data, held_data);
                if (bus.out_ready) begin
                    if (exp_data_q.size() == 0) fail_msg("unexpected_word");
                    else chk("out_data", bus.out_data, exp_data_q.pop_front());
                    out_cnt++;
                    pend_valid = 1'b0;
                end else begin
                    pend_valid = 1'b1;
                    held_data  = bus.out_data;
                end
            end else begin
                pend_valid = 1'b0;
            end
            if (done) begin
                if (exp_err_q.size() == 0) fail_msg("unexpected_done");
                else chk("error_flag", error, exp_err_q.pop_front());
            end
        end
    end

    // ---------------- transfer driver ----------------
    task automatic launch(input logic [31:0] base, input int n);
        @(posedge clk); #2;
        start      = 1'b1;
        base_addr  = base;
        word_count = 16'(n);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] base, input int n);
        bit got;
        expect_xfer(base, n, data_xor);
        launch(base, n);
        // one cycle after the accepting edge
        chk("busy_after_start", busy, 1);
        if (n == 0) begin
            chk("zero_len_done", done, 1);
            chk("zero_len_no_cyc", bus.wbm_cyc_o, 0);
        end else begin
            chk("start_to_stb", bus.wbm_cyc_o, 1);
        end
        // a start while busy must be ignored
        start      = 1'b1;
        base_addr  = $urandom;
        word_count = 16'($urandom_range(1, 9));
        @(posedge clk); #2;
        start = 1'b0;
        if (n > 0) begin
            got = 1'b0;
            for (int c = 0; c < 3000 && !got; c++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            if (!got) fail_msg("done_timeout");
            @(posedge clk); #2;
        end
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("words_left", 32'(exp_data_q.size()), 0);
        chk("reqs_left", 32'(exp_addr_q.size()), 0);
        chk("dones_left", 32'(exp_err_q.size()), 0);
    endtask

    task automatic apply_reset_mid();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_error", error, 0);
        chk("arst_cyc", bus.wbm_cyc_o, 0);
        chk("arst_stb", bus.wbm_stb_o, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_addr", bus.wbm_addr_o, 0);
        flush_model();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        // monitor flags any word or done that shows up here
        repeat (6) @(posedge clk);
        #2;
        chk("idle_after_reset", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit got;
        int cyc_cycles;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = 32'h0;
        word_count = 16'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_addr", bus.wbm_addr_o, 0);
        chk("const_cti", bus.wbm_cti_o, 0);
        chk("const_bte", bus.wbm_bte_o, 0);
        chk("const_sel", bus.wbm_sel_o, 4'hF);
        chk("const_we", bus.wbm_we_o, 0);
        chk("const_wdata", bus.wbm_data_o, 0);
        rst = 1'b0;

        // three words, slave acks after two waits, data = address
        fixed_delay = 2;
        data_xor    = 32'h0;
        run_xfer(32'h0000_0100, 3);

        // zero length
        run_xfer(32'h0000_0200, 0);

        // sink stalls ten cycles on the first word
        fixed_delay = 0;
        data_xor    = 32'hA5A5_5A5A;
        hold_cnt    = 10;
        run_xfer(32'h0000_0400, 2);
        chk("hold_consumed", 32'(hold_cnt), 0);

        // address wrap, plus a base with nonzero low bits
        run_xfer(32'hFFFF_FFFC, 2);
        run_xfer(32'hFFFF_FFFB, 3);

        // randomized traffic
        fixed_delay = -1;
        spurious    = 1'b1;
        rand_ready  = 1'b1;
        for (int i = 0; i < 25; i++) begin
            logic [31:0] b;
            data_xor = $urandom;
            b = (i % 5 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if (i % 7 == 3) hold_cnt = $urandom_range(1, 6);
            run_xfer(b, $urandom_range(0, 6));
        end
        spurious   = 1'b0;
        rand_ready = 1'b0;
        hold_cnt   = 0;

        // slave that never acknowledges
        never_ack = 1'b1;
`ifdef PPCM_LOADER_TIMEOUT_EN
        exp_err_q.push_back(1'b1);
        launch(32'h0000_1000, 3);
        cyc_cycles = 0;
        for (int c = 0; c < 200 && bus.wbm_cyc_o; c++) begin
            cyc_cycles++;
            @(posedge clk); #2;
        end
        chk("timeout_read_cycles", 32'(cyc_cycles), 15);
        chk("timeout_done", done, 1);
        chk("timeout_error", error, 1);
        @(posedge clk); #2;
        chk("timeout_idle", busy, 0);
        chk("timeout_dones_left", 32'(exp_err_q.size()), 0);
        never_ack = 1'b0;
`else
        launch(32'h0000_1000, 3);
        cyc_cycles = 0;
        repeat (60) begin
            @(posedge clk); #2;
            if (bus.wbm_cyc_o) cyc_cycles++;
        end
        chk("stall_read_cycles", 32'(cyc_cycles), 60);
        chk("stall_busy", busy, 1);
        never_ack = 1'b0;
        apply_reset_mid();
`endif

        // reset while reading word 2 of 4, then a clean single-word transfer
        fixed_delay = 3;
        data_xor    = 32'h1234_5678;
        expect_xfer(32'h0000_2000, 4, data_xor);
        out_cnt = 0;
        launch(32'h0000_2000, 4);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (out_cnt == 1 && bus.wbm_cyc_o) got = 1'b1;
            else begin
                @(posedge clk); #2;
            end
        end
        if (!got) fail_msg("word2_read_timeout");
        apply_reset_mid();
        fixed_delay = 1;
        run_xfer(32'h0000_3004, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
